// File: rtl/cache_lru_replacer.sv
// cache_lru_replacer
//   True-LRU replacement tracker, one age vector per set. Touches (hits or
//   fills) age the set. Lookups return a registered victim one cycle later.
//   An invalid way wins over the LRU way.
//
//   Ports
//     CLK, Reset     clock; asynchronous active-high reset
//     flush          synchronous return of all sets to the reset ordering
//     touch_en/_set/_way    record an access to (set, way)
//     lookup_req/_set       request a victim for a set
//     way_valid      valid bits of lookup_set's ways, sampled with lookup_req
//     victim_valid   one-cycle response pulse
//     victim_way     chosen victim; holds its value between pulses
//
//   Age 0 = MRU, age NUM_WAYS-1 = LRU. Within a set the ages are always a
//   permutation of 0..NUM_WAYS-1.

// Per-way aging step. Only the touched set's row is fed through these lanes.
module lru_age_lane #(
   parameter int WAY_W = 2
) (
   input  logic [WAY_W-1:0] old_age,
   input  logic [WAY_W-1:0] hit_age,
   input  logic             is_hit,
   output logic [WAY_W-1:0] new_age
);
   // Only ages below the hit age move, so the increment cannot wrap.
   assign new_age = is_hit               ? '0 :
                    (old_age < hit_age)  ? old_age + WAY_W'(1) :
                                           old_age;
endmodule

module cache_lru_replacer #(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 16,
   parameter int WAY_W    = $clog2(NUM_WAYS),
   parameter int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                flush,
   input  logic                touch_en,
   input  logic [SET_W-1:0]    touch_set,
   input  logic [WAY_W-1:0]    touch_way,
   input  logic                lookup_req,
   input  logic [SET_W-1:0]    lookup_set,
   input  logic [NUM_WAYS-1:0] way_valid,
   output logic                victim_valid,
   output logic [WAY_W-1:0]    victim_way
);

   localparam logic [WAY_W-1:0] LRU_AGE = WAY_W'(NUM_WAYS - 1);

   logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] ages;
   logic [NUM_WAYS-1:0][WAY_W-1:0]               rst_row, t_row, t_next, l_row;
   logic [WAY_W-1:0]                             hit_age, vic;
   logic                                         way_ok, set_ok, touch_go;
   logic                                         accept, vld_q, rst_hold;

   // Indices beyond NUM_WAYS/NUM_SETS only exist for non-power-of-two sizes.
   generate
      if (NUM_WAYS == (1 << WAY_W)) begin : g_way_full
         assign way_ok = 1'b1;
      end else begin : g_way_part
         assign way_ok = (touch_way < WAY_W'(NUM_WAYS));
      end
      if (NUM_SETS == (1 << SET_W)) begin : g_set_full
         assign set_ok = 1'b1;
      end else begin : g_set_part
         assign set_ok = (touch_set < SET_W'(NUM_SETS));
      end
   endgenerate

   assign t_row    = ages[touch_set];
   assign l_row    = ages[lookup_set];
   assign hit_age  = t_row[touch_way];
   assign touch_go = touch_en && way_ok && set_ok;

   genvar g;
   generate
      for (g = 0; g < NUM_WAYS; g++) begin : g_lane
         assign rst_row[g] = WAY_W'(g);
         lru_age_lane #(.WAY_W(WAY_W)) u_lane (
            .old_age (t_row[g]),
            .hit_age (hit_age),
            .is_hit  (touch_way == WAY_W'(g)),
            .new_age (t_next[g])
         );
      end
   endgenerate

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         ages <= {NUM_SETS{rst_row}};
      else if (flush)
         ages <= {NUM_SETS{rst_row}};
      else if (touch_go)
         ages[touch_set] <= t_next;
   end

   // Victim from pre-touch state: lowest invalid way, else the LRU way.
   always_comb begin
      logic found;
      vic   = '0;
      found = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!found && !way_valid[w]) begin
            vic   = WAY_W'(w);
            found = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (l_row[w] == LRU_AGE)
               vic = WAY_W'(w);
         end
      end
   end

   // rst_hold masks lookups on the first edge after Reset drops, so a lookup
   // held across reset never produces a pulse.
   assign accept = lookup_req && !flush && !rst_hold;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         vld_q      <= 1'b0;
         victim_way <= '0;
         rst_hold   <= 1'b1;
      end else if (flush) begin
         vld_q      <= 1'b0;
         victim_way <= '0;
         rst_hold   <= 1'b0;
      end else begin
         vld_q    <= accept;
         rst_hold <= 1'b0;
         if (accept)
            victim_way <= vic;
      end
   end

   assign victim_valid = vld_q;

endmodule
